// File: rtl/fetch_seq_pkg.sv
// Shared state, redirect-kind and address-shift definitions for the fetch sequencer.
package fetch_seq_pkg;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR} fetch_state_e;

   typedef enum logic [1:0] {NONE, BR, JALR} redir_kind_e;

   // PC counts words; memory and redirect interfaces use bytes.
   localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/redirect_buffer.sv
// Pending-redirect store for the fetch sequencer: capture, jalr-over-br priority, newest-wins
// overwrite, and PC control fields. FETCH_MISALIGN_TRAP_EN turns misaligned targets into a trap.
module redirect_buffer
   import fetch_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        capture_en,
   input  logic        apply,
   input  logic        br_valid,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_offset,
   input  logic        jalr_valid,
   input  logic [31:0] jalr_target,
   input  logic [31:0] pc,
   output logic        pending,
   output logic        trap,
   output logic        pc_en,
   output logic        pc_add_en,
   output logic        pc_jalr,
   output logic [31:0] pc_offset,
   output logic [31:0] pc_jalr_addr
);

   redir_kind_e kind_q, eff_kind;
   logic [31:0] br_pc_q, offset_q, target_q;
   logic [31:0] eff_br_pc, eff_offset, eff_target;
   logic        misaligned;
   logic        fire;

   // A pulse arriving this cycle is newer than anything buffered, so it wins outright.
   always_comb begin
      eff_kind   = kind_q;
      eff_br_pc  = br_pc_q;
      eff_offset = offset_q;
      eff_target = target_q;
      if (capture_en && jalr_valid) begin
         eff_kind   = JALR;
         eff_target = jalr_target;
      end else if (capture_en && br_valid) begin
         eff_kind   = BR;
         eff_br_pc  = br_pc;
         eff_offset = br_offset;
      end
   end

   assign pending = (eff_kind != NONE);

`ifdef FETCH_MISALIGN_TRAP_EN
   // Low bits of br_pc*4 + offset are just the offset's low bits.
   always_comb begin
      misaligned = 1'b0;
      if (eff_kind == JALR) begin
         misaligned = (eff_target[1:0] != 2'b00);
      end else if (eff_kind == BR) begin
         misaligned = (eff_offset[1:0] != 2'b00);
      end
   end
`else
   assign misaligned = 1'b0;
`endif

   assign trap         = apply && misaligned;
   assign fire         = apply && !misaligned;
   assign pc_en        = fire;
   assign pc_jalr      = fire && (eff_kind == JALR);
   assign pc_add_en    = fire && (eff_kind == BR);
   assign pc_jalr_addr = pc_jalr ? eff_target : '0;
   // Rebase onto the current PC so the target stays br_pc*4 + offset.
   assign pc_offset    = pc_add_en ? (eff_offset + ((eff_br_pc - pc) << WORD_SHIFT)) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kind_q   <= NONE;
         br_pc_q  <= '0;
         offset_q <= '0;
         target_q <= '0;
      end else begin
         kind_q   <= apply ? NONE : eff_kind;
         br_pc_q  <= eff_br_pc;
         offset_q <= eff_offset;
         target_q <= eff_target;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control FSM: one outstanding imem fetch, valid/ready hand-off to decode, PC stepping and
// branch/JALR redirects. FETCH_MISALIGN_TRAP_EN enables the misaligned-target trap.
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned CNT_W    = 4
) (
   input  logic        clk,
   input  logic        rst_n_i,
   input  logic [31:0] pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i,
   input  logic        br_valid_i,
   input  logic [31:0] br_pc_i,
   input  logic [31:0] br_offset_i,
   input  logic        jalr_valid_i,
   input  logic [31:0] jalr_target_i,
   output logic        pc_en_o,
   output logic        pc_add_en_o,
   output logic        pc_jalr_o,
   output logic [31:0] pc_offset_o,
   output logic [31:0] pc_jalr_addr_o,
   output logic        fetch_err_o,
   output logic        misalign_o
);

   localparam logic [CNT_W:0] MAX_WAIT_W = (CNT_W + 1)'(MAX_WAIT);

   fetch_state_e     state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   cnt_inc;
   logic             timeout;
   logic             pending, trap, apply, step, redir_pc_en;

   assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);
   assign timeout = (MAX_WAIT != 0) && (cnt_inc == MAX_WAIT_W);

   assign apply = pending && ((state == S_HOLD) || ((state == S_WAIT) && imem_ack_i));
   assign step  = (state == S_HOLD) && instr_valid_o && instr_ready_i && !pending;

   assign pc_en_o     = redir_pc_en || step;
   assign imem_addr_o = imem_req_o ? (pc_i << WORD_SHIFT) : '0;

   redirect_buffer u_redirect_buffer (
      .clk          (clk),
      .rst_n        (rst_n_i),
      .capture_en   (state != S_ERR),
      .apply        (apply),
      .br_valid     (br_valid_i),
      .br_pc        (br_pc_i),
      .br_offset    (br_offset_i),
      .jalr_valid   (jalr_valid_i),
      .jalr_target  (jalr_target_i),
      .pc           (pc_i),
      .pending      (pending),
      .trap         (trap),
      .pc_en        (redir_pc_en),
      .pc_add_en    (pc_add_en_o),
      .pc_jalr      (pc_jalr_o),
      .pc_offset    (pc_offset_o),
      .pc_jalr_addr (pc_jalr_addr_o)
   );

   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         state         <= S_IDLE;
         cnt           <= '0;
         imem_req_o    <= 1'b0;
         instr_valid_o <= 1'b0;
         instr_o       <= '0;
         instr_pc_o    <= '0;
         fetch_err_o   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               state      <= S_REQ;
               imem_req_o <= 1'b1;
            end
            S_REQ: begin
               state <= S_WAIT;
               cnt   <= '0;
            end
            S_WAIT: begin
               if (imem_ack_i) begin
                  if (trap) begin
                     state       <= S_ERR;
                     imem_req_o  <= 1'b0;
                     fetch_err_o <= 1'b1;
                  end else if (pending) begin
                     // Squashed response: refetch straight from the redirected PC.
                     state <= S_REQ;
                  end else begin
                     state         <= S_HOLD;
                     imem_req_o    <= 1'b0;
                     instr_valid_o <= 1'b1;
                     instr_o       <= imem_rdata_i;
                     instr_pc_o    <= pc_i;
                  end
               end else if (timeout) begin
                  state       <= S_ERR;
                  imem_req_o  <= 1'b0;
                  fetch_err_o <= 1'b1;
               end else begin
                  cnt <= cnt_inc[CNT_W-1:0];
               end
            end
            S_HOLD: begin
               if (trap) begin
                  state         <= S_ERR;
                  instr_valid_o <= 1'b0;
                  fetch_err_o   <= 1'b1;
               end else if (pending || instr_ready_i) begin
                  state         <= S_REQ;
                  instr_valid_o <= 1'b0;
                  imem_req_o    <= 1'b1;
               end
            end
            S_ERR: begin
               state <= S_ERR;
            end
            default: begin
               state <= S_ERR;
            end
         endcase
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q;

   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         misalign_q <= 1'b0;
      end else if (trap) begin
         misalign_q <= 1'b1;
      end
   end

   assign misalign_o = misalign_q;
`else
   assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, stall, branch/JALR redirects,
// misaligned JALR (both builds), timeout and reset.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic [31:0] pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;
   logic        br_valid_i;
   logic [31:0] br_pc_i;
   logic [31:0] br_offset_i;
   logic        jalr_valid_i;
   logic [31:0] jalr_target_i;
   logic        pc_en_o;
   logic        pc_add_en_o;
   logic        pc_jalr_o;
   logic [31:0] pc_offset_o;
   logic [31:0] pc_jalr_addr_o;
   logic        fetch_err_o;
   logic        misalign_o;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk            (clk),
      .rst_n_i        (rst_n_i),
      .pc_i           (pc_i),
      .imem_req_o     (imem_req_o),
      .imem_addr_o    (imem_addr_o),
      .imem_ack_i     (imem_ack_i),
      .imem_rdata_i   (imem_rdata_i),
      .instr_valid_o  (instr_valid_o),
      .instr_o        (instr_o),
      .instr_pc_o     (instr_pc_o),
      .instr_ready_i  (instr_ready_i),
      .br_valid_i     (br_valid_i),
      .br_pc_i        (br_pc_i),
      .br_offset_i    (br_offset_i),
      .jalr_valid_i   (jalr_valid_i),
      .jalr_target_i  (jalr_target_i),
      .pc_en_o        (pc_en_o),
      .pc_add_en_o    (pc_add_en_o),
      .pc_jalr_o      (pc_jalr_o),
      .pc_offset_o    (pc_offset_o),
      .pc_jalr_addr_o (pc_jalr_addr_o),
      .fetch_err_o    (fetch_err_o),
      .misalign_o     (misalign_o)
   );

   // Program-counter block driven by the DUT's control strobes.
   logic [31:0] pc_byte;
   assign pc_byte = (pc_i << 2) + pc_offset_o;

   always @(posedge clk) begin
      if (!rst_n_i) begin
         pc_i <= '0;
      end else if (pc_en_o) begin
         if (pc_jalr_o) pc_i <= pc_jalr_addr_o >> 2;
         else if (pc_add_en_o) pc_i <= pc_byte >> 2;
         else pc_i <= pc_i + 32'd1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Entered while the DUT sits in S_REQ; leaves it in the following S_REQ.
   task automatic fetch_one(input logic [31:0] data);
      next();
      next();
      imem_ack_i   = 1'b1;
      imem_rdata_i = data;
      next();
      imem_ack_i    = 1'b0;
      instr_ready_i = 1'b1;
      #4;
      check_eq("seq_valid", instr_valid_o, 1);
      check_eq("seq_pc_en", pc_en_o, 1);
      next();
      instr_ready_i = 1'b0;
   endtask

   int unsigned err_at;
   logic        req_at_15;

   initial begin
      rst_n_i       = 1'b0;
      imem_ack_i    = 1'b0;
      imem_rdata_i  = '0;
      instr_ready_i = 1'b0;
      br_valid_i    = 1'b0;
      br_pc_i       = '0;
      br_offset_i   = '0;
      jalr_valid_i  = 1'b0;
      jalr_target_i = '0;
      err_at        = 0;
      req_at_15     = 1'b0;

      repeat (2) next();
      #4;
      check_eq("rst_req", imem_req_o, 0);
      check_eq("rst_addr", imem_addr_o, 0);
      check_eq("rst_valid", instr_valid_o, 0);
      check_eq("rst_pc_en", pc_en_o, 0);
      check_eq("rst_err", fetch_err_o, 0);
      check_eq("rst_misalign", misalign_o, 0);

      // Basic fetch: ack two cycles after the first request cycle.
      next(); rst_n_i = 1'b1;
      next(); #4;
      check_eq("f1_req", imem_req_o, 1);
      check_eq("f1_addr", imem_addr_o, 32'h0);
      next(); #4;
      check_eq("f1_req_held", imem_req_o, 1);
      next(); imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0013; #4;
      check_eq("f1_valid_at_ack", instr_valid_o, 0);
      check_eq("f1_pc_en_at_ack", pc_en_o, 0);
      next(); imem_ack_i = 1'b0; instr_ready_i = 1'b1; #4;
      check_eq("f1_valid", instr_valid_o, 1);
      check_eq("f1_instr", instr_o, 32'h0000_0013);
      check_eq("f1_instr_pc", instr_pc_o, 32'h0);
      check_eq("f1_pc_en", pc_en_o, 1);
      check_eq("f1_add_en", pc_add_en_o, 0);
      check_eq("f1_jalr", pc_jalr_o, 0);
      next(); instr_ready_i = 1'b0; #4;
      check_eq("f1_valid_drop", instr_valid_o, 0);
      check_eq("f2_req", imem_req_o, 1);
      check_eq("f2_addr", imem_addr_o, 32'h4);

      // Decode stalls for five cycles, then accepts once.
      next();
      next(); imem_ack_i = 1'b1; imem_rdata_i = 32'hAAAA_5555;
      next(); imem_ack_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i != 0) next();
         #4;
         check_eq("stall_valid", instr_valid_o, 1);
         check_eq("stall_instr", instr_o, 32'hAAAA_5555);
         check_eq("stall_instr_pc", instr_pc_o, 32'h1);
         check_eq("stall_pc_en", pc_en_o, 0);
      end
      next(); instr_ready_i = 1'b1; #4;
      check_eq("stall_accept_pc_en", pc_en_o, 1);
      next(); instr_ready_i = 1'b0; #4;
      check_eq("stall_single_pc_en", pc_en_o, 0);
      check_eq("f3_addr", imem_addr_o, 32'h8);

      fetch_one(32'h1111_0001);
      fetch_one(32'h1111_0002);
      #4;
      check_eq("f5_addr", imem_addr_o, 32'h10);

      // Branch pulse in S_WAIT, applied at ack: offset -8 + (3-4)*4 = -12.
      next(); br_valid_i = 1'b1; br_pc_i = 32'd3; br_offset_i = 32'hFFFF_FFF8; #4;
      check_eq("br_wait_pc_en", pc_en_o, 0);
      next(); br_valid_i = 1'b0; imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; #4;
      check_eq("br_pc_en", pc_en_o, 1);
      check_eq("br_add_en", pc_add_en_o, 1);
      check_eq("br_jalr", pc_jalr_o, 0);
      check_eq("br_offset", pc_offset_o, 32'hFFFF_FFF4);
      check_eq("br_jalr_addr", pc_jalr_addr_o, 32'h0);
      next(); imem_ack_i = 1'b0; #4;
      check_eq("br_discard_valid", instr_valid_o, 0);
      check_eq("br_refetch_req", imem_req_o, 1);
      check_eq("br_refetch_addr", imem_addr_o, 32'h4);

      // Branch and JALR together in S_HOLD: JALR wins, held instruction squashed.
      next();
      next(); imem_ack_i = 1'b1; imem_rdata_i = 32'h1234_5678;
      next(); imem_ack_i = 1'b0;
      br_valid_i = 1'b1; br_pc_i = 32'd5; br_offset_i = 32'd8;
      jalr_valid_i = 1'b1; jalr_target_i = 32'h100; #4;
      check_eq("jalr_hold_valid", instr_valid_o, 1);
      check_eq("jalr_pc_en", pc_en_o, 1);
      check_eq("jalr_sel", pc_jalr_o, 1);
      check_eq("jalr_addr", pc_jalr_addr_o, 32'h100);
      check_eq("jalr_no_add", pc_add_en_o, 0);
      check_eq("jalr_no_offset", pc_offset_o, 32'h0);
      next(); br_valid_i = 1'b0; jalr_valid_i = 1'b0; #4;
      check_eq("jalr_squash", instr_valid_o, 0);
      check_eq("jalr_refetch_addr", imem_addr_o, 32'h100);

      // Misaligned JALR target in S_HOLD.
      next();
      next(); imem_ack_i = 1'b1; imem_rdata_i = 32'h2222_2222;
      next(); imem_ack_i = 1'b0; jalr_valid_i = 1'b1; jalr_target_i = 32'h102; #4;
`ifdef FETCH_MISALIGN_TRAP_EN
      check_eq("mis_pc_en", pc_en_o, 0);
      next(); jalr_valid_i = 1'b0; #4;
      check_eq("mis_flag", misalign_o, 1);
      check_eq("mis_err", fetch_err_o, 1);
      check_eq("mis_req", imem_req_o, 0);
      check_eq("mis_valid", instr_valid_o, 0);
`else
      check_eq("mis_pc_en", pc_en_o, 1);
      check_eq("mis_jalr", pc_jalr_o, 1);
      check_eq("mis_jalr_addr", pc_jalr_addr_o, 32'h102);
      next(); jalr_valid_i = 1'b0; #4;
      check_eq("mis_flag", misalign_o, 0);
      check_eq("mis_err", fetch_err_o, 0);
      check_eq("mis_req", imem_req_o, 1);
      check_eq("mis_addr", imem_addr_o, 32'h100);
`endif

      // One-cycle reset.
      next(); rst_n_i = 1'b0;
      next(); rst_n_i = 1'b1; #4;
      check_eq("rst2_req", imem_req_o, 0);
      check_eq("rst2_valid", instr_valid_o, 0);
      check_eq("rst2_err", fetch_err_o, 0);
      check_eq("rst2_misalign", misalign_o, 0);
      check_eq("rst2_pc_en", pc_en_o, 0);
      check_eq("rst2_instr", instr_o, 32'h0);
      check_eq("rst2_instr_pc", instr_pc_o, 32'h0);

      // No ack: 15 cycles in S_WAIT, then S_ERR.
      next(); #4;
      check_eq("to_req", imem_req_o, 1);
      check_eq("to_addr", imem_addr_o, 32'h0);
      for (int i = 1; i <= 40; i++) begin
         next(); #4;
         if (i == 15) req_at_15 = imem_req_o;
         if (fetch_err_o) begin
            err_at = i;
            break;
         end
      end
      check_eq("to_cycle", err_at, 16);
      check_eq("to_req_before", req_at_15, 1);
      check_eq("to_req_low", imem_req_o, 0);
      check_eq("to_valid", instr_valid_o, 0);
      next(); imem_ack_i = 1'b1; br_valid_i = 1'b1; br_pc_i = 32'd0; br_offset_i = 32'd4; #4;
      check_eq("err_no_pc_en", pc_en_o, 0);
      next(); imem_ack_i = 1'b0; br_valid_i = 1'b0; #4;
      check_eq("err_sticky", fetch_err_o, 1);
      check_eq("err_no_req", imem_req_o, 0);

      next(); rst_n_i = 1'b0;
      next(); rst_n_i = 1'b1; #4;
      check_eq("rst3_err", fetch_err_o, 0);
      check_eq("rst3_idle_req", imem_req_o, 0);
      next(); #4;
      check_eq("rst3_req", imem_req_o, 1);
      check_eq("rst3_addr", imem_addr_o, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control FSM that sequences the program counter and the instruction-memory fetch port. It issues one outstanding fetch at a time and hands each instruction to decode with a valid/ready handshake. It steps the PC after each handshake and applies taken-branch and JALR redirects from execute, squashing any in-flight fetch. It drives the PC block's enable, add-select, jalr-select, offset and jalr-address inputs. The PC holds a word index; byte addresses appear only on the memory and redirect interfaces.

Parameters:
MAX_WAIT, 15, fetch timeout in cycles spent in S_WAIT; 0 disables the timeout.
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
clk  in  1  clock, rising edge
rst_n_i  in  1  reset, synchronous, active-low
pc_i  in  32  current PC (word index) from the program counter
imem_req_o  out  1  fetch request, level; held until ack
imem_addr_o  out  32  byte address = pc_i << 2
imem_ack_i  in  1  one-cycle response strobe; never in the same cycle as the first req cycle
imem_rdata_i  in  32  instruction word, valid with ack
instr_valid_o  out  1  instruction available to decode
instr_o  out  32  captured instruction
instr_pc_o  out  32  word-index PC of instr_o
instr_ready_i  in  1  decode accepts
br_valid_i  in  1  taken branch/JAL redirect pulse
br_pc_i  in  32  word-index PC of the redirecting instruction
br_offset_i  in  32  signed byte offset relative to br_pc_i
jalr_valid_i  in  1  JALR redirect pulse
jalr_target_i  in  32  absolute byte target
pc_en_o  out  1  one-cycle PC update strobe
pc_add_en_o  out  1  PC uses the offset path
pc_jalr_o  out  1  PC uses the absolute path
pc_offset_o  out  32  byte offset to the PC's add path
pc_jalr_addr_o  out  32  byte address to the PC's absolute path
fetch_err_o  out  1  sticky: timeout or misalign trap
misalign_o  out  1  sticky misaligned-target flag (tied 0 without the macro)

Behaviour:
- Reset, when rst_n_i is low at a clk edge: state S_IDLE, every output 0, pending-redirect buffer empty, wait counter 0. Reset mid-fetch drops imem_req_o at that edge; a late ack is ignored.
- S_IDLE: advances to S_REQ on the next cycle.
- S_REQ: imem_req_o=1 with imem_addr_o. Always advances to S_WAIT.
- S_WAIT:
  - imem_req_o stays 1 and the counter increments each cycle.
  - On ack with no pending redirect: latch rdata into instr_o and pc_i into instr_pc_o, go to S_HOLD. instr_valid_o rises one cycle after ack.
  - On ack with a pending redirect: discard the data, apply the redirect, go to S_REQ.
- S_HOLD:
  - instr_valid_o=1; instr_o and instr_pc_o stay stable until handshake.
  - On valid and ready: pc_en_o=1 with add_en=0 and jalr=0 (sequential +1), instr_valid_o drops next cycle, go to S_REQ.
- Redirect capture:
  - br/jalr pulses in any non-error state load the pending buffer.
  - jalr beats br in the same cycle. A newer redirect overwrites an older one, including one in the same cycle it would be applied.
- Redirect apply:
  - In S_HOLD, apply immediately (same cycle as the pulse or the cycle after capture). This replaces the +1 step, squashes the held instruction (instr_valid_o=0 next cycle, no handshake needed) and goes to S_REQ.
  - In S_REQ or S_WAIT, apply at ack.
  - Apply means pc_en_o=1 for one cycle. For JALR: pc_jalr_o=1, pc_jalr_addr_o=jalr_target_i.
  - For a branch: pc_add_en_o=1, pc_offset_o = br_offset_i + ((br_pc_i - pc_i) << 2), modulo 2^32. This makes the target br_pc_i*4 + br_offset_i regardless of how far the PC has already advanced.
  - Applying a redirect clears the buffer.
- Timeout: counter reaching MAX_WAIT in S_WAIT moves to S_ERR.
- S_ERR: imem_req_o=0, instr_valid_o=0, fetch_err_o=1. Only reset exits.
- pc_add_en_o, pc_jalr_o, pc_offset_o and pc_jalr_addr_o are 0 whenever pc_en_o=0.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: on apply, if the computed byte target (jalr_target_i, or br_pc_i*4 + br_offset_i) has bits[1:0] != 0, there is no pc_en_o. The block goes to S_ERR with misalign_o=1 and fetch_err_o=1.
- Undefined: the low bits are silently truncated by the PC's divide-by-4 and misalign_o is tied 0.

Decomposition:
- Package fetch_seq_pkg holds:
  - the state enum S_IDLE/S_REQ/S_WAIT/S_HOLD/S_ERR;
  - the redirect-kind enum NONE/BR/JALR;
  - the WORD_SHIFT=2 constant.
- Sub-module redirect_buffer holds the pending redirect: kind, br_pc, offset, target, priority and overwrite rules. It outputs the ready-to-drive PC control fields.

Test Plan:
- Reset release, pc_i=0, ack 2 cycles after req, ready=1 -> imem_addr_o=0, instr_valid_o one cycle after ack, pc_en_o pulse with add_en=0, next req at addr 4.
- Valid held with ready=0 for 5 cycles -> instr_o/instr_pc_o stable, no pc_en_o; ready=1 -> single pc_en_o.
- br_valid_i with br_pc_i=3, br_offset_i=-8, pulsed while S_WAIT at pc_i=4 -> response discarded, pc_offset_o=-12, pc_add_en_o=1, next fetch addr 4.
- br_valid_i and jalr_valid_i (target 0x100) in the same cycle during S_HOLD -> held instruction squashed, pc_jalr_o=1, pc_jalr_addr_o=0x100, no br applied.
- No ack for MAX_WAIT=15 cycles -> S_ERR, fetch_err_o=1, req low; rst_n_i low one cycle -> all outputs 0, S_IDLE.
- With FETCH_MISALIGN_TRAP_EN, jalr_target_i=0x102 -> no pc_en_o, misalign_o=1, fetch_err_o=1; without the macro -> pc_jalr_o=1, pc_jalr_addr_o=0x102.
